// File: rtl/mux_8_1_scan_ctrl.sv
// rtl/mux_8_1_scan_ctrl.sv - drives a word onto an 8:1 mux, walks the selects and captures the reconstructed word
module mux_8_1_scan_ctrl #(
    parameter int DWELL = 1,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       D0,
    output logic       D1,
    output logic       D2,
    output logic       D3,
    output logic       D4,
    output logic       D5,
    output logic       D6,
    output logic       D7,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    input  logic       mux_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_err,
    output logic [3:0] mismatch_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A DWELL of 0 would never sample, so it behaves as a single-cycle dwell.
    localparam int              DWELL_EFF  = (DWELL < 1) ? 1 : DWELL;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    logic [7:0]       r_d;
    logic [7:0]       r_exp;
    logic [7:0]       r_out_data;
    logic [2:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic             r_out_err;
    logic             r_busy;
    logic [3:0]       r_mismatch_cnt;

    logic [7:0]       w_final_data;
    logic [7:0]       w_diff;
    logic [3:0]       w_pop;

    // Captured word including the bit being sampled this cycle, and its distance from the expected word.
    always_comb begin
        w_final_data        = r_out_data;
        w_final_data[r_sel] = mux_out;
        w_diff              = w_final_data ^ r_exp;
        w_pop               = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'd0, w_diff[i]};
        end
    end

    // Scan sequencer: accept a word, walk sel 0..7 with DWELL cycles each, present the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_d            <= 8'd0;
            r_exp          <= 8'd0;
            r_out_data     <= 8'd0;
            r_sel          <= 3'd0;
            r_cnt          <= '0;
            r_out_valid    <= 1'b0;
            r_out_err      <= 1'b0;
            r_busy         <= 1'b0;
            r_mismatch_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_d        <= in_data;
                        r_exp      <= in_data;
                        r_out_data <= 8'd0;
                        r_sel      <= 3'd0;
                        r_cnt      <= CNT_RELOAD;
                        r_busy     <= 1'b1;
                        r_state    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_out_data <= w_final_data;
                        if (r_sel == 3'd7) begin
                            // Result flags come from the completed word on the same edge it is captured.
                            r_out_err      <= (w_pop != 4'd0);
                            r_mismatch_cnt <= w_pop;
                            r_out_valid    <= 1'b1;
                            r_busy         <= 1'b0;
                            r_state        <= ST_DONE;
                        end else begin
                            r_sel <= r_sel + 3'd1;
                            r_cnt <= CNT_RELOAD;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready only in IDLE and never while reset is asserted.
    assign in_ready     = rst_n && (r_state == ST_IDLE);

    assign D0           = r_d[0];
    assign D1           = r_d[1];
    assign D2           = r_d[2];
    assign D3           = r_d[3];
    assign D4           = r_d[4];
    assign D5           = r_d[5];
    assign D6           = r_d[6];
    assign D7           = r_d[7];
    assign S0           = r_sel[0];
    assign S1           = r_sel[1];
    assign S2           = r_sel[2];
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_err      = r_out_err;
    assign mismatch_cnt = r_mismatch_cnt;
    assign busy         = r_busy;

endmodule

// File: tb/tb_mux_8_1_scan_ctrl.sv
// tb/tb_mux_8_1_scan_ctrl.sv - self-checking bench for mux_8_1_scan_ctrl with DWELL=1 and DWELL=3 instances
module tb_mux_8_1_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      in_valid;
    logic [1:0]      out_ready;
    logic [1:0][7:0] in_data;
    wire  [1:0]      in_ready;
    wire  [1:0]      out_valid;
    wire  [1:0]      out_err;
    wire  [1:0]      busy;
    wire  [1:0]      mux_out;
    wire  [1:0][7:0] d_w;
    wire  [1:0][7:0] out_data;
    wire  [1:0][2:0] s_w;
    wire  [1:0][3:0] mcnt;
    int              fault_mode [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural mux_8_1 per instance: 0 = healthy, 1 = stuck at 0, 2 = stuck at 1.
    assign mux_out[0] = (fault_mode[0] == 1) ? 1'b0 : (fault_mode[0] == 2) ? 1'b1 : d_w[0][s_w[0]];
    assign mux_out[1] = (fault_mode[1] == 1) ? 1'b0 : (fault_mode[1] == 2) ? 1'b1 : d_w[1][s_w[1]];

    mux_8_1_scan_ctrl #(.DWELL(1), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .D0(d_w[0][0]), .D1(d_w[0][1]), .D2(d_w[0][2]), .D3(d_w[0][3]),
        .D4(d_w[0][4]), .D5(d_w[0][5]), .D6(d_w[0][6]), .D7(d_w[0][7]),
        .S0(s_w[0][0]), .S1(s_w[0][1]), .S2(s_w[0][2]),
        .mux_out(mux_out[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_err(out_err[0]), .mismatch_cnt(mcnt[0]), .busy(busy[0])
    );

    mux_8_1_scan_ctrl #(.DWELL(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .D0(d_w[1][0]), .D1(d_w[1][1]), .D2(d_w[1][2]), .D3(d_w[1][3]),
        .D4(d_w[1][4]), .D5(d_w[1][5]), .D6(d_w[1][6]), .D7(d_w[1][7]),
        .S0(s_w[1][0]), .S1(s_w[1][1]), .S2(s_w[1][2]),
        .mux_out(mux_out[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_err(out_err[1]), .mismatch_cnt(mcnt[1]), .busy(busy[1])
    );

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         fault;
        int         bp;
        logic [7:0] exp_data;
        logic       exp_err;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word the scan must reconstruct: each bit is what the mux returns for that select.
    function automatic logic [7:0] model_word(input logic [7:0] data, input int fault);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i] = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : data[i];
        end
        return w;
    endfunction

    // Offer one word at a negedge where the DUT is idle, follow the scan, then drain with bp stalled cycles.
    task automatic run_word(input int k, input logic [7:0] data, input int fault, input int bp,
                            input logic [7:0] ed, input logic ee, input logic [3:0] ec);
        int dw;
        int lat;
        dw = (k == 0) ? 1 : 3;
        fault_mode[k] = fault;
        chk("in_ready_before_accept", {31'd0, in_ready[k]}, 32'd1);
        in_data[k]   = data;
        in_valid[k]  = 1'b1;
        out_ready[k] = (bp == 0);
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_data[k]  = ~data;
        // The accept edge counts as the first edge of the latency.
        lat = 1;
        while (!out_valid[k] && lat < 100) begin
            chk("busy_in_scan", {31'd0, busy[k]}, 32'd1);
            chk("sel_sequence", {29'd0, s_w[k]}, 32'((lat - 1) / dw));
            chk("d_stable", {24'd0, d_w[k]}, {24'd0, data});
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 8 * dw + 1);
        chk("out_data", {24'd0, out_data[k]}, {24'd0, ed});
        chk("out_err", {31'd0, out_err[k]}, {31'd0, ee});
        chk("mismatch_cnt", {28'd0, mcnt[k]}, {28'd0, ec});
        chk("busy_done", {31'd0, busy[k]}, 32'd0);
        for (int i = 0; i < bp; i++) begin
            in_valid[k] = 1'b1;
            chk("bp_in_ready", {31'd0, in_ready[k]}, 32'd0);
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid[k]}, 32'd1);
            chk("bp_out_data", {24'd0, out_data[k]}, {24'd0, ed});
            chk("bp_out_err", {31'd0, out_err[k]}, {31'd0, ee});
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge clk);
        chk("drain_out_valid", {31'd0, out_valid[k]}, 32'd0);
        chk("drain_in_ready", {31'd0, in_ready[k]}, 32'd1);
        chk("drain_data_hold", {24'd0, out_data[k]}, {24'd0, ed});
        chk("drain_cnt_hold", {28'd0, mcnt[k]}, {28'd0, ec});
        chk("drain_d_hold", {24'd0, d_w[k]}, {24'd0, data});
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rexp;
        int         rk;
        int         rf;

        vecs[0] = '{inst: 0, data: 8'h55, fault: 0, bp: 0, exp_data: 8'h55, exp_err: 1'b0, exp_cnt: 4'd0};
        vecs[1] = '{inst: 0, data: 8'h55, fault: 1, bp: 0, exp_data: 8'h00, exp_err: 1'b1, exp_cnt: 4'd4};
        vecs[2] = '{inst: 0, data: 8'h00, fault: 2, bp: 0, exp_data: 8'hFF, exp_err: 1'b1, exp_cnt: 4'd8};
        vecs[3] = '{inst: 0, data: 8'h55, fault: 0, bp: 5, exp_data: 8'h55, exp_err: 1'b0, exp_cnt: 4'd0};
        vecs[4] = '{inst: 1, data: 8'hA3, fault: 0, bp: 0, exp_data: 8'hA3, exp_err: 1'b0, exp_cnt: 4'd0};
        vecs[5] = '{inst: 1, data: 8'h5A, fault: 2, bp: 2, exp_data: 8'hFF, exp_err: 1'b1, exp_cnt: 4'd4};
        vecs[6] = '{inst: 0, data: 8'h55, fault: 0, bp: 0, exp_data: 8'h55, exp_err: 1'b0, exp_cnt: 4'd0};
        vecs[7] = '{inst: 0, data: 8'hAA, fault: 0, bp: 0, exp_data: 8'hAA, exp_err: 1'b0, exp_cnt: 4'd0};

        rst_n         = 1'b0;
        in_valid      = 2'b00;
        out_ready     = 2'b00;
        in_data       = '0;
        fault_mode[0] = 0;
        fault_mode[1] = 0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", {31'd0, in_ready[k]}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid[k]}, 32'd0);
            chk("rst_busy", {31'd0, busy[k]}, 32'd0);
            chk("rst_d", {24'd0, d_w[k]}, 32'd0);
            chk("rst_sel", {29'd0, s_w[k]}, 32'd0);
            chk("rst_out_data", {24'd0, out_data[k]}, 32'd0);
            chk("rst_err_cnt", {27'd0, out_err[k], mcnt[k]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {30'd0, in_ready}, 32'd3);

        // Directed table; entries 6 and 7 run back-to-back with out_ready high.
        for (int v = 0; v < 8; v++) begin
            run_word(vecs[v].inst, vecs[v].data, vecs[v].fault, vecs[v].bp,
                     vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_cnt);
        end

        // Reset while S2:S0 = 100 on the DWELL=1 instance.
        fault_mode[0] = 0;
        in_data[0]    = 8'h3C;
        in_valid[0]   = 1'b1;
        out_ready[0]  = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("midscan_sel", {29'd0, s_w[0]}, 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midscan_rst_d", {24'd0, d_w[0]}, 32'd0);
        chk("midscan_rst_sel", {29'd0, s_w[0]}, 32'd0);
        chk("midscan_rst_flags", {29'd0, out_valid[0], busy[0], in_ready[0]}, 32'd0);
        chk("midscan_rst_out", {20'd0, out_data[0], mcnt[0]}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midscan_no_valid", {30'd0, out_valid}, 32'd0);
        end
        chk("midscan_in_ready", {31'd0, in_ready[0]}, 32'd1);
        run_word(0, 8'h0F, 0, 0, 8'h0F, 1'b0, 4'd0);

        // Randomised words against the reference model.
        for (int r = 0; r < 16; r++) begin
            rk   = int'($urandom_range(1, 0));
            rf   = int'($urandom_range(2, 0));
            rd   = 8'($urandom);
            rexp = model_word(rd, rf);
            run_word(rk, rd, rf, int'($urandom_range(3, 0)), rexp, (rexp != rd),
                     4'($countones(rexp ^ rd)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
